// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - register map and shared constants for the interrupt controller
package irq_ctrl_pkg;

   localparam int NSRC_MAX      = 15;
   localparam int VEC_VALID_BIT = 15;

   // Register addresses, also consumed by the software header generator.
   typedef enum logic [1:0] {
      IRQ_PEND = 2'd0,
      IRQ_EN   = 2'd1,
      IRQ_VEC  = 2'd2,
      IRQ_MODE = 2'd3
   } irq_reg_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - d16 slave bus bundle between syscon/CPU side and the interrupt controller
interface irq_ctrl_if;

   logic        i_cyc;
   logic        i_we;
   logic [1:0]  i_addr;
   logic [15:0] i_dat;
   logic [15:0] o_dat;

   modport master (
      output i_cyc, i_we, i_addr, i_dat,
      input  o_dat
   );

   modport slave (
      input  i_cyc, i_we, i_addr, i_dat,
      output o_dat
   );

endinterface

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - two-flop request synchronizer with one extra stage for rise detection
module irq_sync #(
   parameter int NSRC = 8
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic [NSRC-1:0] i_irq,
   output logic [NSRC-1:0] s2,
   output logic [NSRC-1:0] rise
);

   logic [NSRC-1:0] s1;
   logic [NSRC-1:0] s3;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= i_irq;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // s3 clears with reset, so a request held high through reset rises again.
   assign rise = s2 & ~s3;

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - masked, fixed-priority interrupt controller driving the d16 CPU interrupt line
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int NSRC = 8
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic [NSRC-1:0] i_irq,
   irq_ctrl_if.slave       bus,
   output logic            o_int
);

   logic [NSRC-1:0] s2;
   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] pend;
   logic [NSRC-1:0] en;
   logic [NSRC-1:0] mode;
   logic [NSRC-1:0] w1c;
   logic [NSRC-1:0] active;
   logic [NSRC-1:0] wr_data;
   logic            wr;
   irq_reg_e        addr;
   logic [15:0]     vec;
   logic            unused_dat_hi;

   // Lowest-numbered active source wins.
   function automatic logic [3:0] lowest_idx(input logic [NSRC-1:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   irq_sync #(.NSRC(NSRC)) u_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_irq   (i_irq),
      .s2      (s2),
      .rise    (rise)
   );

   assign addr          = irq_reg_e'(bus.i_addr);
   assign wr            = bus.i_cyc & bus.i_we;
   assign wr_data       = bus.i_dat[NSRC-1:0];
   assign unused_dat_hi = &{1'b0, bus.i_dat[15:NSRC]};
   assign w1c           = (wr && addr == IRQ_PEND) ? wr_data : '0;
   assign active        = pend & en;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         pend  <= '0;
         en    <= '0;
         mode  <= '0;
         o_int <= 1'b0;
      end else begin
         if (wr && addr == IRQ_EN)   en   <= wr_data;
         if (wr && addr == IRQ_MODE) mode <= wr_data;
         // Edge sources: a new rise beats a same-cycle clear. Level sources track s2.
         pend  <= (mode & (rise | (pend & ~w1c))) | (~mode & s2);
         o_int <= |active;
      end
   end

   always_comb begin
      vec                = '0;
      vec[VEC_VALID_BIT] = |active;
      vec[3:0]           = lowest_idx(active);
   end

   always_comb begin
      bus.o_dat = '0;
      if (bus.i_cyc) begin
         case (addr)
            IRQ_PEND: bus.o_dat = {{(16-NSRC){1'b0}}, pend};
            IRQ_EN:   bus.o_dat = {{(16-NSRC){1'b0}}, en};
            IRQ_VEC:  bus.o_dat = vec;
            IRQ_MODE: bus.o_dat = {{(16-NSRC){1'b0}}, mode};
            default:  bus.o_dat = '0;
         endcase
      end
   end

endmodule
